fifo_route_ctrl: RTL and testbench
==================================

// Module: fifo_route_ctrl
// PURPOSE
//  Downstream consumer of the main FIFO. Pops words whenever the FIFO is non-empty and no
//  destination is near full. Routes each popped word to one of 4 output FIFOs using its top
//  2 bits. Keeps per-channel word counters and flags protocol errors.
// PARAMETERS
//  DW   8  data width; bits [DW-1:DW-2] = destination channel 0..3
//  CW   8  width of each per-channel delivered-word counter (wraps)
// PORTS
//  clk              in   1      clock; all state updates on rising edge
//  reset            in   1      asynchronous, active-low reset
//  up_data          in   DW     upstream FIFO data_out
//  up_valid         in   1      upstream valid_out; up_data valid this cycle
//  up_empty         in   1      upstream fifo_empty
//  up_pop           out  1      pop request to upstream FIFO
//  down_almost_full in   4      almost-full flag of each output FIFO, bit i = channel i
//  down_push        out  4      one-hot push to output FIFO i
//  down_data        out  DW     data to all output FIFOs (qualified by down_push)
//  cnt_sel          in   2      selects which channel counter appears on cnt_out
//  cnt_out          out  CW     delivered-word count of channel cnt_sel
//  idle             out  1      1 = no word in flight and upstream empty
//  error            out  1      sticky protocol error
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE; up_pop, down_push, down_data, counters and error = 0; idle = 1.
//  Upstream timing:
//   - Pop at cycle N returns up_valid/up_data at N+1. Back-to-back pops allowed.
//  States: IDLE, ACTIVE, PAUSE, ERROR (registered).
//   - pause = |down_almost_full.
//   - IDLE  -> ACTIVE when !up_empty && !pause; -> PAUSE when !up_empty && pause.
//   - ACTIVE -> PAUSE when pause; -> IDLE when up_empty and no word in flight.
//   - PAUSE -> ACTIVE when !pause && !up_empty; -> IDLE when !pause && up_empty.
//   - any   -> ERROR on protocol error. ERROR is left only by reset.
//  up_pop (combinational):
//   - up_pop = (state==ACTIVE || next-from-IDLE/PAUSE conditions met) && !up_empty && !pause.
//   - Never asserted in ERROR or when up_empty=1.
//  Routing (registered, 1-cycle latency):
//   - up_valid=1 at cycle M -> down_data=up_data and down_push[up_data[DW-1:DW-2]]=1 at M+1.
//   - Otherwise down_push=0 and down_data holds its last value.
//   - A word already in flight is delivered even if pause rises meanwhile.
//     Almost-full thresholds must leave >=2 words of margin.
//  Counters:
//   - cnt[i] increments on each cycle down_push[i]=1 and wraps 2^CW-1 -> 0.
//   - cnt_out = cnt[cnt_sel], combinational.
//  In-flight tracking:
//   - inflight is set by up_pop and cleared by up_valid.
//   - idle = (state==IDLE) && !inflight.
//  Error (sticky):
//   - Set on up_valid=1 without a pop in the previous cycle.
//   - Set on a missing up_valid one cycle after a pop.
//   - Once set: up_pop=0 and down_push=0 until reset.
//  Reset mid-operation:
//   - Any in-flight word is dropped; counters clear; no push is issued after reset deasserts
//     until a new pop/valid pair occurs.
// TESTING
//  1 Reset: hold reset=0 for 2 cycles -> all outputs 0 except idle=1; cnt_out=0 for every cnt_sel.
//  2 Routing: upstream holds 0x05,0x47,0x8A,0xC3, no almost_full -> 4 pops back-to-back;
//    down_push 0001,0010,0100,1000 each one cycle after valid; every cnt=1.
//  3 Pause: down_almost_full=0100 while 3 words remain -> up_pop drops the same cycle;
//    the in-flight word is still pushed; clearing the flag resumes popping the remaining 3.
//  4 Empty/idle: upstream goes empty after last pop -> up_pop=0, idle=1 one cycle after last valid.
//  5 Error: up_valid=1 with no prior pop -> error=1 next cycle; no further up_pop or down_push
//    until reset=0.
//  6 Wrap + mid-reset: push 256 words to channel 2 -> cnt[2]=0x00; reset=0 while a pop is in
//    flight -> no down_push after reset release.

Source files
------------

// File: rtl/fifo_route_ctrl.sv
// fifo_route_ctrl: pops words from the main FIFO and steers each one to one of
// four output FIFOs selected by the word's top two bits. Tracks the word in
// flight, keeps per-channel delivered-word counters and latches protocol errors.
module fifo_route_ctrl #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] up_data,
  input  logic          up_valid,
  input  logic          up_empty,
  output logic          up_pop,
  input  logic [3:0]    down_almost_full,
  output logic [3:0]    down_push,
  output logic [DW-1:0] down_data,
  input  logic [1:0]    cnt_sel,
  output logic [CW-1:0] cnt_out,
  output logic          idle,
  output logic          error
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_PAUSE  = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          inflight_q, inflight_d;
  logic          popped_q, popped_d;
  logic          error_q, error_d;
  logic [3:0]    push_q, push_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  logic pause;
  logic proto_err;
  logic accept;

  // Any destination near full stalls new pops; words already popped still land.
  assign pause = |down_almost_full;

  // Upstream answers a pop exactly one cycle later, so valid must mirror last cycle's pop.
  assign proto_err = (state_q != S_ERROR) && (up_valid != popped_q);

  // The IDLE/PAUSE exit conditions and ACTIVE all reduce to "not errored, data, no pause".
  assign up_pop = (state_q != S_ERROR) && !up_empty && !pause;

  // A returned word is accepted only when it answers our own pop.
  assign accept = up_valid && popped_q && (state_q != S_ERROR);

  // Next-state, in-flight tracking, routing and error latch.
  always_comb begin
    state_d    = state_q;
    inflight_d = inflight_q;
    popped_d   = up_pop;
    error_d    = error_q | proto_err;
    push_d     = 4'b0000;
    data_d     = data_q;

    if (up_pop) begin
      inflight_d = 1'b1;
    end else if (up_valid) begin
      inflight_d = 1'b0;
    end

    if (accept) begin
      push_d = 4'b0001 << up_data[DW-1:DW-2];
      data_d = up_data;
    end

    if (proto_err) begin
      state_d = S_ERROR;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!up_empty && !pause)     state_d = S_ACTIVE;
          else if (!up_empty && pause) state_d = S_PAUSE;
        end
        S_ACTIVE: begin
          if (pause)                         state_d = S_PAUSE;
          else if (up_empty && !inflight_d) state_d = S_IDLE;
        end
        S_PAUSE: begin
          if (!pause && !up_empty)     state_d = S_ACTIVE;
          else if (!pause && up_empty) state_d = S_IDLE;
        end
        default: state_d = S_ERROR;
      endcase
    end
  end

  // Per-channel counters advance on the cycle their push is presented and wrap freely.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    assign cnt_d[gi] = cnt_q[gi] + {{(CW-1){1'b0}}, push_q[gi]};
  end

  // All state and registered outputs; reset drops any in-flight word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      inflight_q <= 1'b0;
      popped_q   <= 1'b0;
      error_q    <= 1'b0;
      push_q     <= 4'b0000;
      data_q     <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      popped_q   <= popped_d;
      error_q    <= error_d;
      push_q     <= push_d;
      data_q     <= data_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign down_push = push_q;
  assign down_data = data_q;
  assign cnt_out   = cnt_q[cnt_sel];
  assign idle      = (state_q == S_IDLE) && !inflight_q;
  assign error     = error_q;

endmodule

// File: tb/tb_fifo_route_ctrl.sv
// Directed bench for fifo_route_ctrl: a queue models the upstream FIFO
// (word appears one cycle after a pop); vector tables hold stimulus and
// hand-computed expected results.
module tb_fifo_route_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] up_data;
  logic       up_valid;
  logic       up_empty;
  logic       up_pop;
  logic [3:0] down_almost_full;
  logic [3:0] down_push;
  logic [7:0] down_data;
  logic [1:0] cnt_sel;
  logic [7:0] cnt_out;
  logic       idle;
  logic       error;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] q [$];

  typedef struct {
    logic       empty;
    logic [3:0] af;
    logic       exp_pop;
  } pop_vec_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] exp_push;
  } route_vec_t;

  pop_vec_t   pv_tab [6];
  route_vec_t rv_tab [8];

  fifo_route_ctrl #(.DW(8), .CW(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .up_data          (up_data),
    .up_valid         (up_valid),
    .up_empty         (up_empty),
    .up_pop           (up_pop),
    .down_almost_full (down_almost_full),
    .down_push        (down_push),
    .down_data        (down_data),
    .cnt_sel          (cnt_sel),
    .cnt_out          (cnt_out),
    .idle             (idle),
    .error            (error)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at a negedge; advances one clock and returns at the next negedge.
  task automatic tick();
    logic pop_s;
    #1;
    pop_s = up_pop;
    @(posedge clk);
    #1;
    if (pop_s && q.size() > 0) begin
      up_valid = 1'b1;
      up_data  = q.pop_front();
    end else begin
      up_valid = 1'b0;
    end
    up_empty = (q.size() == 0);
    @(negedge clk);
  endtask

  // Runs the upstream until table entries [first, first+n) have all been pushed.
  task automatic drain(input int first, input int n, input int budget);
    int   k;
    logic pv;
    k = first;
    for (int c = 0; c < budget && k < first + n; c++) begin
      pv = up_valid;
      tick();
      if (pv) begin
        check($sformatf("route%0d_push", k), down_push, rv_tab[k].exp_push);
        check($sformatf("route%0d_data", k), down_data, rv_tab[k].data);
        k++;
      end else begin
        check("route_nopush", down_push, 4'b0000);
      end
    end
    check("route_done", k - first, n);
  endtask

  task automatic load(input int first, input int n);
    for (int i = first; i < first + n; i++) q.push_back(rv_tab[i].data);
    up_empty = (q.size() == 0);
  endtask

  task automatic check_cnt(input logic [1:0] sel, input logic [7:0] exp);
    cnt_sel = sel;
    #1;
    check($sformatf("cnt%0d", sel), cnt_out, exp);
  endtask

  initial begin
    int n;

    pv_tab[0] = '{1'b1, 4'b0000, 1'b0};
    pv_tab[1] = '{1'b0, 4'b0000, 1'b1};
    pv_tab[2] = '{1'b0, 4'b0100, 1'b0};
    pv_tab[3] = '{1'b0, 4'b1000, 1'b0};
    pv_tab[4] = '{1'b1, 4'b0001, 1'b0};
    pv_tab[5] = '{1'b0, 4'b0001, 1'b0};

    rv_tab[0] = '{8'h05, 4'b0001};
    rv_tab[1] = '{8'h47, 4'b0010};
    rv_tab[2] = '{8'h8A, 4'b0100};
    rv_tab[3] = '{8'hC3, 4'b1000};
    rv_tab[4] = '{8'h11, 4'b0001};
    rv_tab[5] = '{8'h52, 4'b0010};
    rv_tab[6] = '{8'h93, 4'b0100};
    rv_tab[7] = '{8'hD4, 4'b1000};

    reset            = 1'b0;
    up_data          = 8'h00;
    up_valid         = 1'b0;
    up_empty         = 1'b1;
    down_almost_full = 4'b0000;
    cnt_sel          = 2'd0;

    // Reset held two cycles
    @(negedge clk);
    @(negedge clk);
    check("rst_pop", up_pop, 1'b0);
    check("rst_push", down_push, 4'b0000);
    check("rst_data", down_data, 8'h00);
    check("rst_idle", idle, 1'b1);
    check("rst_error", error, 1'b0);
    for (int s = 0; s < 4; s++) check_cnt(2'(s), 8'h00);
    reset = 1'b1;
    tick();

    // Combinational up_pop in IDLE, all within one low clock phase
    for (int i = 0; i < 6; i++) begin
      up_empty         = pv_tab[i].empty;
      down_almost_full = pv_tab[i].af;
      #1;
      check($sformatf("pop_vec%0d", i), up_pop, pv_tab[i].exp_pop);
    end
    up_empty         = 1'b1;
    down_almost_full = 4'b0000;
    #1;

    // Back-to-back routing of four words, then idle timing
    load(0, 4);
    drain(0, 4, 12);
    check("idle_after_last", idle, 1'b1);
    check("pop_after_last", up_pop, 1'b0);
    tick();
    for (int s = 0; s < 4; s++) check_cnt(2'(s), 8'h01);

    // Pause with one word in flight
    load(4, 4);
    tick();
    down_almost_full = 4'b0100;
    #1;
    check("pause_pop_drop", up_pop, 1'b0);
    tick();
    check("inflight_push", down_push, 4'b0001);
    check("inflight_data", down_data, 8'h11);
    tick();
    check("pause_nopush", down_push, 4'b0000);
    check("pause_nopop", up_pop, 1'b0);
    check("pause_qsize", q.size(), 3);
    down_almost_full = 4'b0000;
    #1;
    check("resume_pop", up_pop, 1'b1);
    drain(5, 3, 12);
    tick();
    for (int s = 0; s < 4; s++) check_cnt(2'(s), 8'h02);
    check("idle_after_pause", idle, 1'b1);

    // Unsolicited up_valid
    up_valid = 1'b1;
    up_data  = 8'h00;
    tick();
    check("err_set", error, 1'b1);
    check("err_nopush", down_push, 4'b0000);
    check("err_idle", idle, 1'b0);
    q.push_back(8'h40);
    q.push_back(8'h80);
    up_empty = 1'b0;
    #1;
    check("err_nopop", up_pop, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("err_hold_push", down_push, 4'b0000);
      check("err_sticky", error, 1'b1);
    end
    check("err_qsize", q.size(), 2);
    reset = 1'b0;
    q.delete();
    up_empty = 1'b1;
    up_valid = 1'b0;
    tick();
    tick();
    check("err_cleared", error, 1'b0);
    check("err_rst_idle", idle, 1'b1);
    reset = 1'b1;
    tick();

    // 256 words to channel 2: counter wraps
    cnt_sel = 2'd2;
    for (int i = 0; i < 256; i++) q.push_back(8'h80 | 8'(i % 64));
    up_empty = 1'b0;
    n = 0;
    for (int c = 0; c < 700 && n < 256; c++) begin
      tick();
      if (down_push == 4'b0100) begin
        n++;
        if (n == 256) check("wrap_ff", cnt_out, 8'hFF);
      end
    end
    check("wrap_pushes", n, 256);
    tick();
    check("wrap_zero", cnt_out, 8'h00);
    check_cnt(2'd0, 8'h00);

    // Reset while a pop is in flight
    q.push_back(8'h81);
    q.push_back(8'h82);
    q.push_back(8'h47);
    up_empty = 1'b0;
    tick();
    tick();
    tick();
    check_cnt(2'd2, 8'h01);
    check("mid_inflight", up_valid, 1'b1);
    reset    = 1'b0;
    up_valid = 1'b0;
    q.delete();
    up_empty = 1'b1;
    #1;
    check("mid_rst_push", down_push, 4'b0000);
    check("mid_rst_cnt", cnt_out, 8'h00);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_nopush", down_push, 4'b0000);
      check("post_rst_noerr", error, 1'b0);
    end
    check("post_rst_idle", idle, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
